// File: rtl/victory_pkg.sv
// Shared types, state encodings and default parameters for the victory tracker.
// Scores are 2 bits wide, so a configured win target must be 3 or less.
package victory_pkg;

  localparam int unsigned DEF_WIN_TARGET        = 2;
  localparam int unsigned DEF_MAX_MATCHES       = 5;
  localparam int unsigned DEF_NEXT_DELAY_CYCLES = 200_000_000;

  typedef enum logic [1:0] {
    TIE = 2'b00,
    P1  = 2'b01,
    P2  = 2'b10
  } win_t;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_PLAYING = 3'd1;
  localparam state_t ST_SCORE   = 3'd2;
  localparam state_t ST_DELAY   = 3'd3;
  localparam state_t ST_ADVANCE = 3'd4;
  localparam state_t ST_FINAL   = 3'd5;

  function automatic win_t champion_of(input logic [1:0] p1, input logic [1:0] p2);
    if (p1 > p2) return P1;
    if (p2 > p1) return P2;
    return TIE;
  endfunction

endpackage

// File: rtl/delay_counter.sv
// Free-running delay timer: counts while en is high, pulses done on the last count,
// and returns to zero whenever en drops.
module delay_counter #(
  parameter int unsigned CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic done
);

  localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  assign done = en && (cnt_q == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!en || done) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/victory_tracker_fsm.sv
// Best-of-N series tracker: scores each match and decides when the series ends.
// Define VICTORY_AUTO_ADVANCE_EN for timed advance; otherwise confirm advances.
module victory_tracker_fsm
  import victory_pkg::*;
#(
  parameter int unsigned WIN_TARGET        = DEF_WIN_TARGET,
  parameter int unsigned MAX_MATCHES       = DEF_MAX_MATCHES,
  parameter int unsigned NEXT_DELAY_CYCLES = DEF_NEXT_DELAY_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       restart,
  input  logic       game_end,
  input  logic [1:0] game_win,
  input  logic       confirm,
  output logic       next_match,
  output logic       final_state,
  output logic [1:0] champion,
  output logic [1:0] p1_score,
  output logic [1:0] p2_score,
  output logic [2:0] match_num
);

  localparam logic [1:0] WIN_TGT   = 2'(WIN_TARGET);
  localparam logic [2:0] MAX_MATCH = 3'(MAX_MATCHES);

  state_t     state_q, state_d;
  logic [1:0] win_q, win_d;
  logic [1:0] p1_q, p1_d;
  logic [1:0] p2_q, p2_d;
  logic [2:0] match_q, match_d;
  logic       final_q, final_d;
  logic [1:0] champ_q, champ_d;
  logic       next_q, next_d;
  logic       advance;

`ifdef VICTORY_AUTO_ADVANCE_EN
  logic delay_en;
  logic delay_done;
  logic unused_confirm;

  assign unused_confirm = confirm;

  // Timing window opens in SCORE so next_match lands NEXT_DELAY_CYCLES after scoring.
  assign delay_en = ((state_q == ST_SCORE) || (state_q == ST_DELAY)) && !restart;

  delay_counter #(
    .CYCLES (NEXT_DELAY_CYCLES)
  ) u_delay_counter (
    .clk  (clk),
    .rst  (rst),
    .en   (delay_en),
    .done (delay_done)
  );

  assign advance = delay_done;
`else
  logic confirm_q;
  logic unused_delay_cfg;

  assign unused_delay_cfg = (NEXT_DELAY_CYCLES == 0);

  // Button pulse is registered once before it steers the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      confirm_q <= 1'b0;
    end else begin
      confirm_q <= confirm;
    end
  end

  assign advance = confirm_q;
`endif

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    match_d = match_q;
    final_d = final_q;
    champ_d = champ_q;
    next_d  = 1'b0;

    if (restart && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      win_d   = TIE;
      p1_d    = '0;
      p2_d    = '0;
      match_d = '0;
      final_d = 1'b0;
      champ_d = TIE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_PLAYING;
            p1_d    = '0;
            p2_d    = '0;
            match_d = 3'd1;
          end
        end
        ST_PLAYING: begin
          if (game_end) begin
            win_d   = game_win;
            state_d = ST_SCORE;
          end
        end
        ST_SCORE: begin
          p1_d = p1_q + ((win_q == P1) ? 2'd1 : 2'd0);
          p2_d = p2_q + ((win_q == P2) ? 2'd1 : 2'd0);
          if ((p1_d == WIN_TGT) || (p2_d == WIN_TGT) || (match_q == MAX_MATCH)) begin
            state_d = ST_FINAL;
            final_d = 1'b1;
            champ_d = champion_of(p1_d, p2_d);
          end else begin
            state_d = ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (advance) begin
            state_d = ST_ADVANCE;
            next_d  = 1'b1;
            match_d = match_q + 3'd1;
          end
        end
        ST_ADVANCE: begin
          state_d = ST_PLAYING;
        end
        ST_FINAL: begin
          state_d = ST_FINAL;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      win_q   <= TIE;
      p1_q    <= '0;
      p2_q    <= '0;
      match_q <= '0;
      final_q <= 1'b0;
      champ_q <= TIE;
      next_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      match_q <= match_d;
      final_q <= final_d;
      champ_q <= champ_d;
      next_q  <= next_d;
    end
  end

  assign next_match  = next_q;
  assign final_state = final_q;
  assign champion    = champ_q;
  assign p1_score    = p1_q;
  assign p2_score    = p2_q;
  assign match_num   = match_q;

endmodule

// File: tb/tb_victory_tracker_fsm.sv
// Directed bench for victory_tracker_fsm (WIN_TARGET=2, MAX_MATCHES=5, delay 10).
// Advance latency is counted from the cycle holding the triggering pulse.
module tb_victory_tracker_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       restart;
  logic       game_end;
  logic [1:0] game_win;
  logic       confirm;
  logic       next_match;
  logic       final_state;
  logic [1:0] champion;
  logic [1:0] p1_score;
  logic [1:0] p2_score;
  logic [2:0] match_num;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef VICTORY_AUTO_ADVANCE_EN
  localparam int ADV_LAT = 11;
`else
  localparam int ADV_LAT = 2;
`endif

  always #5 clk = ~clk;

  victory_tracker_fsm #(
    .WIN_TARGET        (2),
    .MAX_MATCHES       (5),
    .NEXT_DELAY_CYCLES (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .restart     (restart),
    .game_end    (game_end),
    .game_win    (game_win),
    .confirm     (confirm),
    .next_match  (next_match),
    .final_state (final_state),
    .champion    (champion),
    .p1_score    (p1_score),
    .p2_score    (p2_score),
    .match_num   (match_num)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; restart = 1'b0; game_end = 1'b0; game_win = 2'b00; confirm = 1'b0;
    tick(2);
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1; tick(); restart = 1'b0;
  endtask

  task automatic play_match(input logic [1:0] win);
    game_win = win; game_end = 1'b1; tick(); game_end = 1'b0; game_win = 2'b00;
  endtask

  // Returns cycles since the trigger cycle, or -1 if next_match never rose.
  task automatic wait_next(input int limit, output int lat);
    lat = 1;
    while (next_match !== 1'b1 && lat < limit) begin
      tick();
      lat++;
    end
    if (next_match !== 1'b1) lat = -1;
  endtask

  task automatic advance(output int lat);
`ifdef VICTORY_AUTO_ADVANCE_EN
    wait_next(40, lat);
`else
    tick();
    confirm = 1'b1; tick(); confirm = 1'b0;
    wait_next(40, lat);
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; restart = 1'b0; game_end = 1'b0; game_win = 2'b00; confirm = 1'b0;
    #3;
    n_checks++;
    if (next_match !== 1'b0) begin
      n_fail++; $display("FAIL reset_next_match: got %b want 0", next_match);
    end
    n_checks++;
    if ({final_state, champion} !== 3'b000) begin
      n_fail++; $display("FAIL reset_final: got %b want 000", {final_state, champion});
    end
    n_checks++;
    if ({p1_score, p2_score, match_num} !== 7'd0) begin
      n_fail++; $display("FAIL reset_counts: got %b want 0000000", {p1_score, p2_score, match_num});
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_series_p1();
    int lat;
    do_reset();
    pulse_start();
    n_checks++;
    if ({match_num, final_state} !== {3'd1, 1'b0}) begin
      n_fail++; $display("FAIL start_match_num: got %0d want 1", match_num);
    end
    play_match(2'b01);
    advance(lat);
    n_checks++;
    if (lat !== ADV_LAT) begin
      n_fail++; $display("FAIL m1_latency: got %0d want %0d", lat, ADV_LAT);
    end
    n_checks++;
    if ({p1_score, p2_score, match_num} !== {2'd1, 2'd0, 3'd2}) begin
      n_fail++; $display("FAIL m1_scores: got %0d/%0d m%0d want 1/0 m2", p1_score, p2_score, match_num);
    end
    tick();
    n_checks++;
    if (next_match !== 1'b0) begin
      n_fail++; $display("FAIL m1_pulse_width: got %b want 0", next_match);
    end
    play_match(2'b10);
    advance(lat);
    n_checks++;
    if (lat !== ADV_LAT) begin
      n_fail++; $display("FAIL m2_latency: got %0d want %0d", lat, ADV_LAT);
    end
    tick();
    play_match(2'b01);
    tick();
    n_checks++;
    if ({final_state, champion} !== 3'b101) begin
      n_fail++; $display("FAIL p1_final: got %b want 101", {final_state, champion});
    end
    n_checks++;
    if ({p1_score, p2_score, match_num} !== {2'd2, 2'd1, 3'd3}) begin
      n_fail++; $display("FAIL p1_final_counts: got %0d/%0d m%0d want 2/1 m3", p1_score, p2_score,
                         match_num);
    end
  endtask

  task automatic test_draw_cap();
    int lat;
    logic [1:0] wins [4];
    wins = '{2'b01, 2'b10, 2'b00, 2'b11};
    do_reset();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      play_match(wins[i]);
      advance(lat);
      tick();
    end
    n_checks++;
    if ({final_state, match_num, p1_score, p2_score} !== {1'b0, 3'd5, 2'd1, 2'd1}) begin
      n_fail++; $display("FAIL before_m5: got f%b m%0d %0d/%0d want f0 m5 1/1", final_state, match_num,
                         p1_score, p2_score);
    end
    play_match(2'b00);
    tick();
    n_checks++;
    if ({final_state, champion, p1_score, p2_score, match_num} !== {1'b1, 2'b00, 2'd1, 2'd1, 3'd5}) begin
      n_fail++; $display("FAIL draw_final: got f%b c%b %0d/%0d m%0d want f1 c00 1/1 m5", final_state,
                         champion, p1_score, p2_score, match_num);
    end
  endtask

  task automatic test_final_hold();
    logic moved;
    moved = 1'b0;
    pulse_start();
    play_match(2'b01);
    confirm = 1'b1; tick(); confirm = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (next_match !== 1'b0 || {final_state, champion, p1_score, p2_score, match_num}
          !== {1'b1, 2'b00, 2'd1, 2'd1, 3'd5}) moved = 1'b1;
      tick();
    end
    n_checks++;
    if (moved !== 1'b0) begin
      n_fail++; $display("FAIL final_hold: outputs changed=%b want 0", moved);
    end
    pulse_restart();
    n_checks++;
    if ({final_state, champion, p1_score, p2_score, match_num} !== 10'd0) begin
      n_fail++; $display("FAIL final_restart: got %b want 0", {final_state, champion, p1_score,
                         p2_score, match_num});
    end
    pulse_start();
    n_checks++;
    if (match_num !== 3'd1) begin
      n_fail++; $display("FAIL restart_to_idle: got m%0d want 1", match_num);
    end
  endtask

  task automatic test_restart_priority();
    logic seen;
    seen = 1'b0;
    do_reset();
    pulse_start();
    game_win = 2'b01; game_end = 1'b1; restart = 1'b1;
    tick();
    game_end = 1'b0; restart = 1'b0; game_win = 2'b00;
    n_checks++;
    if ({final_state, p1_score, p2_score, match_num} !== 8'd0) begin
      n_fail++; $display("FAIL restart_prio: got %b want 0", {final_state, p1_score, p2_score, match_num});
    end
    confirm = 1'b1; tick(); confirm = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (next_match !== 1'b0 || p1_score !== 2'd0) seen = 1'b1;
      tick();
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL restart_no_next: activity=%b want 0", seen);
    end
    pulse_restart();
    n_checks++;
    if (match_num !== 3'd0) begin
      n_fail++; $display("FAIL idle_restart_noop: got m%0d want 0", match_num);
    end
  endtask

  task automatic test_rst_mid_delay();
    int lat;
    do_reset();
    pulse_start();
    play_match(2'b01);
    tick(5);
    n_checks++;
    if (p1_score !== 2'd1) begin
      n_fail++; $display("FAIL pre_rst_score: got %0d want 1", p1_score);
    end
    #1 rst = 1'b1;
    #2;
    n_checks++;
    if ({next_match, final_state, champion, p1_score, p2_score, match_num} !== 11'd0) begin
      n_fail++; $display("FAIL async_rst: got %b want 0", {next_match, final_state, champion,
                         p1_score, p2_score, match_num});
    end
    #1 rst = 1'b0;
    tick();
    pulse_start();
    play_match(2'b10);
    advance(lat);
    n_checks++;
    if (lat !== ADV_LAT) begin
      n_fail++; $display("FAIL post_rst_latency: got %0d want %0d", lat, ADV_LAT);
    end
    n_checks++;
    if ({p1_score, p2_score, match_num} !== {2'd0, 2'd1, 3'd2}) begin
      n_fail++; $display("FAIL post_rst_scores: got %0d/%0d m%0d want 0/1 m2", p1_score, p2_score,
                         match_num);
    end
  endtask

`ifndef VICTORY_AUTO_ADVANCE_EN
  task automatic test_manual_hold();
    int lat;
    logic seen;
    seen = 1'b0;
    do_reset();
    pulse_start();
    play_match(2'b10);
    for (int i = 0; i < 1000; i++) begin
      if (next_match !== 1'b0) seen = 1'b1;
      tick();
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL manual_wait: next_match seen=%b want 0", seen);
    end
    n_checks++;
    if ({p2_score, match_num} !== {2'd1, 3'd1}) begin
      n_fail++; $display("FAIL manual_wait_state: got p2=%0d m%0d want 1 m1", p2_score, match_num);
    end
    confirm = 1'b1; tick(); confirm = 1'b0;
    wait_next(20, lat);
    n_checks++;
    if (lat !== 2) begin
      n_fail++; $display("FAIL confirm_latency: got %0d want 2", lat);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_series_p1();
    test_draw_cap();
    test_final_hold();
    test_restart_priority();
    test_rst_mid_delay();
`ifndef VICTORY_AUTO_ADVANCE_EN
    test_manual_hold();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, limit 1000000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
